// File: rtl/scfifo_li_ctrl.sv
// Show-ahead valid/ready FIFO controller that drives an external registered-read RAM.
// Define SCFIFO_RDW_BYPASS_EN to let reads target the entry written in the same cycle.
module scfifo_li_ctrl #(
    parameter int WIDTH = 10,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ADDR+1:0]  o_count,
    output logic [ADDR-1:0]  o_ram_wr_addr,
    output logic             o_ram_wr_ena,
    output logic [WIDTH-1:0] o_ram_data,
    output logic [ADDR-1:0]  o_ram_rd_addr,
    input  logic [WIDTH-1:0] i_ram_data
);
    localparam int PW = ADDR + 1;
    localparam int CW = ADDR + 2;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    ram_count;
    logic [PW-1:0]    full_lvl;
    logic             rd_pending;
    logic [WIDTH-1:0] head;
    logic             head_v;
    logic [WIDTH-1:0] skid;
    logic             skid_v;
    logic             push;
    logic             pop;
    logic             avail;
    logic [1:0]       stage_load;
    logic             rd_issue;

    assign full_lvl  = {1'b1, {ADDR{1'b0}}};
    assign ram_count = wr_ptr - rd_ptr;

    assign o_ready = (ram_count != full_lvl) & ~reset;
    assign push    = i_valid & o_ready;
    assign pop     = head_v & i_ready;

`ifdef SCFIFO_RDW_BYPASS_EN
    // The RAM returns the new word when read and write hit the same address.
    assign avail = (ram_count != '0) | push;
`else
    assign avail = (ram_count != '0);
`endif

    // Output-stage slots still claimed after this cycle's pop.
    assign stage_load = {1'b0, head_v} + {1'b0, skid_v}
                      + {1'b0, rd_pending} - {1'b0, pop};
    assign rd_issue   = avail & (stage_load < 2'd2);

    assign o_ram_wr_ena  = push;
    assign o_ram_wr_addr = wr_ptr[ADDR-1:0];
    assign o_ram_data    = i_data;
    assign o_ram_rd_addr = rd_ptr[ADDR-1:0];

    assign o_data  = head;
    assign o_valid = head_v;
    assign o_count = CW'(ram_count) + CW'(rd_pending)
                   + CW'(head_v) + CW'(skid_v);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
            head       <= '0;
            head_v     <= 1'b0;
            skid       <= '0;
            skid_v     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            rd_pending <= rd_issue;

            if (pop) begin
                if (skid_v) begin
                    head   <= skid;
                    skid_v <= rd_pending;
                    if (rd_pending) begin
                        skid <= i_ram_data;
                    end
                end else if (rd_pending) begin
                    head <= i_ram_data;
                end else begin
                    head_v <= 1'b0;
                end
            end else if (rd_pending) begin
                if (!head_v) begin
                    head   <= i_ram_data;
                    head_v <= 1'b1;
                end else begin
                    skid   <= i_ram_data;
                    skid_v <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_scfifo_li_ctrl.sv
// Directed bench for scfifo_li_ctrl with a new-data read-during-write RAM model.
module tb_scfifo_li_ctrl;
    localparam int WIDTH = 10;
    localparam int ADDR  = 4;
`ifdef SCFIFO_RDW_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] i_data = '0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [ADDR+1:0]  o_count;
    logic [ADDR-1:0]  o_ram_wr_addr;
    logic             o_ram_wr_ena;
    logic [WIDTH-1:0] o_ram_data;
    logic [ADDR-1:0]  o_ram_rd_addr;
    logic [WIDTH-1:0] i_ram_data;

    logic [WIDTH-1:0] mem [2**ADDR];

    int total = 0;
    int bad = 0;

    scfifo_li_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_count       (o_count),
        .o_ram_wr_addr (o_ram_wr_addr),
        .o_ram_wr_ena  (o_ram_wr_ena),
        .o_ram_data    (o_ram_data),
        .o_ram_rd_addr (o_ram_rd_addr),
        .i_ram_data    (i_ram_data)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (o_ram_wr_ena) begin
            mem[o_ram_wr_addr] <= o_ram_data;
        end
        if (o_ram_wr_ena && o_ram_wr_addr == o_ram_rd_addr) begin
            i_ram_data <= o_ram_data;
        end else begin
            i_ram_data <= mem[o_ram_rd_addr];
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b1;
        i_ready = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        check("rst_rdy", int'(o_ready), 0);
        check("rst_wena", int'(o_ram_wr_ena), 0);
        i_valid = 1'b0;
        reset   = 1'b0;
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_cnt", int'(o_count), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_rdy1", int'(o_ready), 1);
    endtask

    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] e;
    int acc, k, sent, got, err, rdy_err, cnt_err, n;

    initial begin
        // Latency: three back-to-back pushes into an empty FIFO
        do_reset();
        i_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            i_valid = (c < 3);
            i_data  = WIDTH'(c + 1);
            check("lat_valid", int'(o_valid),
                  int'(c >= LAT && c < LAT + 3));
            if (o_valid) begin
                check("lat_data", int'(o_data), c - LAT + 1);
            end
            tick();
        end
        i_valid = 1'b0;

        // Fill with consumer stalled, then drain
        do_reset();
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            i_valid = 1'b1;
            i_data  = WIDTH'(10'h100 + acc);
            if (o_ready) begin
                acc++;
            end
            tick();
        end
        i_valid = 1'b0;
        check("fill_accepts", acc, 18);
        check("fill_cnt", int'(o_count), 18);
        check("fill_rdy", int'(o_ready), 0);
        k = 0;
        for (int c = 0; c < 60; c++) begin
            i_ready = 1'b1;
            i_valid = (c == 0);
            i_data  = 10'h1FF;
            if (c == 0) begin
                check("full_rdy_lo", int'(o_ready), 0);
            end
            if (c == 1) begin
                check("full_rdy_up", int'(o_ready), 1);
            end
            if (o_valid) begin
                check("fill_data", int'(o_data), 'h100 + k);
                k++;
            end
            tick();
        end
        check("drain_pops", k, 18);
        check("drain_cnt", int'(o_count), 0);

        // Streaming at one beat per cycle
        do_reset();
        q.delete();
        got = 0; err = 0; rdy_err = 0; cnt_err = 0;
        for (int c = 0; c < 100; c++) begin
            i_valid = 1'b1;
            i_ready = 1'b1;
            i_data  = WIDTH'(c);
            if (!o_ready) rdy_err++;
            if (c >= LAT && int'(o_count) != LAT) cnt_err++;
            if (o_valid) begin
                got++;
                if (q.size() == 0) err++;
                else begin
                    e = q.pop_front();
                    if (o_data != e) err++;
                end
            end
            if (o_ready) q.push_back(i_data);
            tick();
        end
        i_valid = 1'b0;
        check("stream_rdy", rdy_err, 0);
        check("stream_cnt", cnt_err, 0);
        check("stream_beats", got, 100 - LAT);
        check("stream_data", err, 0);

        // Random stalls across pointer wraps
        do_reset();
        q.delete();
        sent = 0; got = 0; err = 0;
        for (int c = 0; c < 2000 && (sent < 40 || q.size() > 0); c++) begin
            i_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_data  = WIDTH'(10'h150 + sent);
            if (i_ready && o_valid) begin
                got++;
                if (q.size() == 0) err++;
                else begin
                    e = q.pop_front();
                    if (o_data != e) err++;
                end
            end
            if (i_valid && o_ready) begin
                q.push_back(i_data);
                sent++;
            end
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("wrap_sent", sent, 40);
        check("wrap_got", got, 40);
        check("wrap_order", err, 0);
        check("wrap_cnt", int'(o_count), 0);
        check("wrap_valid", int'(o_valid), 0);

        // Reset mid-operation
        do_reset();
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1;
            i_data  = WIDTH'(10'h30 + c);
            tick();
        end
        i_valid = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_valid", int'(o_valid), 0);
        check("mid_cnt", int'(o_count), 0);
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_data  = 10'h2AA;
        tick();
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 10) begin
            tick();
            n++;
        end
        check("mid_lat", n, LAT);
        check("mid_data", int'(o_data), 'h2AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scfifo_li_ctrl.md
# scfifo_li_ctrl

Latency-insensitive FIFO controller that drives an external simple dual-port RAM. The RAM has a registered read port with new-data read-during-write behaviour and no read enable. The controller accepts a valid/ready upstream stream and manages write/read pointers. It absorbs the RAM's 1-cycle read latency with a 2-entry output stage, so the downstream consumer sees a show-ahead valid/ready stream at full throughput. It sits between a producer channel and its consumer.

## Interface
- WIDTH, 10, data width; must equal the RAM width
- ADDR, 4, RAM address width; RAM depth is 2**ADDR
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_data  in  WIDTH  upstream data
- i_valid  in  1  upstream data valid
- o_ready  out  1  upstream may push this cycle
- o_data  out  WIDTH  head-of-FIFO data (registered)
- o_valid  out  1  o_data valid (registered)
- i_ready  in  1  downstream accepts o_data this cycle
- o_count  out  ADDR+2  total occupancy: RAM entries + pending read + output-stage entries
- o_ram_wr_addr  out  ADDR  RAM write address
- o_ram_wr_ena  out  1  RAM write enable
- o_ram_data  out  WIDTH  RAM write data (= i_data)
- o_ram_rd_addr  out  ADDR  RAM read address
- i_ram_data  in  WIDTH  RAM registered read data

## Operation
- State: wr_ptr, rd_ptr (ADDR+1 bits each; extra MSB is the wrap bit), ram_count = wr_ptr - rd_ptr (mod 2**(ADDR+1)), rd_pending (1 bit), head reg + valid, skid reg + valid.
- push = i_valid & o_ready. pop = o_valid & i_ready.
- o_ready = (ram_count != 2**ADDR) & ~reset. Depends only on registered state, never on i_ready. There is no pass-through when full.
- o_ram_wr_ena = push. o_ram_wr_addr = wr_ptr[ADDR-1:0]. wr_ptr increments on push.
- o_ram_rd_addr = rd_ptr[ADDR-1:0], always driven.
- Read issue, rd_issue: requires avail > 0 and (occ_out + rd_pending - pop) < 2.
  - avail = ram_count + push with the bypass macro; avail = ram_count without it.
  - occ_out is the number of valid output-stage entries (0..2).
- rd_ptr increments on rd_issue. rd_pending <= rd_issue.
- When rd_pending is set, i_ram_data is loaded into the output stage:
  - into the head if the head is empty or being popped and the skid is empty;
  - otherwise into the skid.
- On pop with the skid valid, head <= skid and the skid is freed.
- Order is strictly FIFO. Pointer wrap is handled by the MSB and is transparent.
- o_count = ram_count + rd_pending + occ_out; maximum 2**ADDR + 2.
- Ignored conditions:
  - push when o_ready = 0;
  - i_ready when o_valid = 0.
- Simultaneous push and pop are legal in every state, including empty and full-RAM.

## Timing
- Reset (synchronous) clears pointers, rd_pending, head/skid valids and o_data.
  - o_valid = 0, o_data = 0, o_count = 0.
  - o_ram_wr_ena = 0 and o_ready = 0 while reset is high.
  - o_ready = 1 in the first cycle after reset.
- Reset asserted mid-operation discards all contents. The RAM is not cleared; stale contents are unreachable.
- Push accepted in cycle N into an empty FIFO gives o_valid = 1 in cycle N+2 with the bypass macro, N+3 without it.
- Sustained throughput is 1 beat/cycle in both directions.
- A downstream stall never drops or duplicates data: the skid holds the in-flight read.

## Configuration
- SCFIFO_RDW_BYPASS_EN defined:
  - a read may target the entry being written in the same cycle;
  - relies on the RAM's new-data read-during-write behaviour;
  - empty-to-valid latency is 2 cycles.
- SCFIFO_RDW_BYPASS_EN undefined:
  - reads only target entries written in earlier cycles;
  - safe with old-data or undefined read-during-write RAMs;
  - latency is 3 cycles.
  - Capacity and throughput are unchanged.

## Test plan
- Latency: after reset, push 0x001, 0x002, 0x003 in cycles 0..2 with i_ready = 1 → o_valid in cycles 2..4 with data 0x001, 0x002, 0x003 (bypass build); cycles 3..5 in the non-bypass build.
- Fill (ADDR=4): hold i_ready = 0 and push 0x100..0x111 → o_ready drops after exactly 18 accepts and o_count = 18. Then pop all → data 0x100..0x111 in order and o_count returns to 0.
- Streaming: i_valid = i_ready = 1 for 100 cycles with an incrementing pattern → o_ready stays 1, one beat per cycle, o_count steady at 2 (bypass).
- Wrap and stalls: push 40 values with a pseudo-random i_valid/i_ready pattern → output order is exactly the input order across two pointer wraps, with no loss or duplicates.
- Reset mid-operation: push 5 values, pulse reset for 1 cycle → o_valid = 0 and o_count = 0 next cycle. A subsequent push of 0x2AA is the first value output.
- Full simultaneous events: RAM full with the output stage full. Pop while i_valid = 1 → no push is accepted that cycle; o_ready rises one cycle later.
